// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared game timing constants for the pclk domain
package input_conditioner_pkg;

    localparam int PCLK_HZ = 65_000_000;

    // Button conditioning defaults derived from the 65 MHz pixel clock.
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int DEBOUNCE_10MS     = PCLK_HZ / 100;   // 650000
    localparam int REPEAT_FIRST_0S5  = PCLK_HZ / 2;     // 32500000
    localparam int REPEAT_PERIOD_0S2 = PCLK_HZ / 5;     // 13000000

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw button inputs and conditioned control outputs
// master: drives the raw buttons, observes the conditioned outputs
// slave : the conditioner itself
interface input_conditioner_if;
    logic btn_left_in;
    logic btn_right_in;
    logic btn_fire_in;
    logic left_out;
    logic right_out;
    logic fire_pulse_out;
    logic fire_held_out;

    modport master (
        output btn_left_in, btn_right_in, btn_fire_in,
        input  left_out, right_out, fire_pulse_out, fire_held_out
    );

    modport slave (
        input  btn_left_in, btn_right_in, btn_fire_in,
        output left_out, right_out, fire_pulse_out, fire_held_out
    );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// rtl/input_conditioner_debounce_channel.sv - synchroniser chain plus debounce counter for one button
// pclk      : clock
// rst       : synchronous active-high reset
// raw_in    : asynchronous raw button
// level_out : debounced level in pclk
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic pclk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   stable_q, stable_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
        stable_d = stable_q;
        count_d  = '0;
        // Any cycle the synchronised level agrees with the accepted one
        // wipes the count, so a short glitch leaves nothing behind.
        if (s != stable_q) begin
            if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_q   <= '0;
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            count_q  <= count_d;
            stable_q <= stable_d;
        end
    end

    assign level_out = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced left/right levels and auto-repeating fire pulses for draw_ship
// pclk : pixel clock, sole clock
// rst  : synchronous active-high reset
// io   : raw buttons in, left_out/right_out/fire_pulse_out/fire_held_out out
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_FIRST    = REPEAT_FIRST_0S5,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_0S2
) (
    input  logic                pclk,
    input  logic                rst,
    input_conditioner_if.slave  io
);
    localparam int RCW = $clog2(max_int(REPEAT_FIRST, REPEAT_PERIOD) + 1);

    typedef enum logic [1:0] {
        F_IDLE,
        F_FIRST,
        F_REPEAT,
        F_HOLD
    } fire_state_e;

    logic st_left, st_right, st_fire;

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .pclk(pclk), .rst(rst), .raw_in(io.btn_left_in), .level_out(st_left)
    );
    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .pclk(pclk), .rst(rst), .raw_in(io.btn_right_in), .level_out(st_right)
    );
    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
        .pclk(pclk), .rst(rst), .raw_in(io.btn_fire_in), .level_out(st_fire)
    );

    // Level outputs: pressing both directions cancels to neither.
    logic left_q, left_d, right_q, right_d, held_q, held_d;

    always_comb begin
        left_d  = st_left & ~st_right;
        right_d = st_right & ~st_left;
        held_d  = st_fire;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            held_q  <= held_d;
        end
    end

    // Fire FSM. The idle state can only be entered with st_fire low, so
    // st_fire high while idle is the rising edge.
    fire_state_e    state_q;
    logic [RCW-1:0] rcnt_q;
    logic           fire_pulse_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= F_IDLE;
            rcnt_q       <= '0;
            fire_pulse_q <= 1'b0;
        end else begin
            fire_pulse_q <= 1'b0;
            case (state_q)
                F_IDLE: begin
                    if (st_fire) begin
                        fire_pulse_q <= 1'b1;
                        rcnt_q       <= '0;
                        state_q      <= (REPEAT_FIRST == 0) ? F_HOLD : F_FIRST;
                    end
                end
                F_FIRST: begin
                    // Release wins over a coincident terminal count.
                    if (!st_fire) begin
                        state_q <= F_IDLE;
                    end else if (rcnt_q == RCW'(REPEAT_FIRST - 1)) begin
                        fire_pulse_q <= 1'b1;
                        rcnt_q       <= '0;
                        state_q      <= F_REPEAT;
                    end else begin
                        rcnt_q <= rcnt_q + RCW'(1);
                    end
                end
                F_REPEAT: begin
                    if (!st_fire) begin
                        state_q <= F_IDLE;
                    end else if (rcnt_q == RCW'(REPEAT_PERIOD - 1)) begin
                        fire_pulse_q <= 1'b1;
                        rcnt_q       <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + RCW'(1);
                    end
                end
                F_HOLD: begin
                    if (!st_fire) begin
                        state_q <= F_IDLE;
                    end
                end
                default: state_q <= F_IDLE;
            endcase
        end
    end

    assign io.left_out       = left_q;
    assign io.right_out      = right_q;
    assign io.fire_held_out  = held_q;
    assign io.fire_pulse_out = fire_pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    input_conditioner_if ifc ();

    input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_FIRST(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .io(ifc)
    );

    always #5 pclk = ~pclk;

    // One active edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        ifc.btn_left_in  = 1'b1;
        ifc.btn_right_in = 1'b1;
        ifc.btn_fire_in  = 1'b1;
        rst = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            checks++;
            if ({ifc.left_out, ifc.right_out, ifc.fire_pulse_out, ifc.fire_held_out} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs n=%0d got=%b exp=0000", n,
                         {ifc.left_out, ifc.right_out, ifc.fire_pulse_out, ifc.fire_held_out});
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            step();
            checks++;
            if ({ifc.left_out, ifc.right_out} !== 2'b00) begin
                errors++;
                $display("FAIL reset_both_dir n=%0d got=%b exp=00", n, {ifc.left_out, ifc.right_out});
            end
            checks++;
            if (ifc.fire_pulse_out !== (n == 7)) begin
                errors++;
                $display("FAIL reset_fire_pulse n=%0d got=%b exp=%b", n, ifc.fire_pulse_out, (n == 7));
            end
            checks++;
            if (ifc.fire_held_out !== (n >= 7)) begin
                errors++;
                $display("FAIL reset_fire_held n=%0d got=%b exp=%b", n, ifc.fire_held_out, (n >= 7));
            end
        end
        ifc.btn_left_in  = 1'b0;
        ifc.btn_right_in = 1'b0;
        ifc.btn_fire_in  = 1'b0;
        idle_wait(20);
    endtask

    task automatic test_left_press();
        ifc.btn_left_in = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            step();
            checks++;
            if (ifc.left_out !== (n >= 7 && n < 27)) begin
                errors++;
                $display("FAIL left_level n=%0d got=%b exp=%b", n, ifc.left_out, (n >= 7 && n < 27));
            end
            checks++;
            if (ifc.right_out !== 1'b0) begin
                errors++;
                $display("FAIL left_right_quiet n=%0d got=%b exp=0", n, ifc.right_out);
            end
            if (n == 20) ifc.btn_left_in = 1'b0;
        end
        idle_wait(10);
    endtask

    task automatic test_glitch();
        ifc.btn_left_in = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step();
            checks++;
            if (ifc.left_out !== (n >= 19)) begin
                errors++;
                $display("FAIL glitch_left n=%0d got=%b exp=%b", n, ifc.left_out, (n >= 19));
            end
            ifc.btn_left_in = (n <= 2) || (n >= 4 && n <= 6) || (n >= 12);
        end
        ifc.btn_left_in = 1'b0;
        idle_wait(10);
    endtask

    task automatic test_fire_repeat();
        logic exp_p;
        ifc.btn_fire_in = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            step();
            exp_p = (n == 7) || (n == 17) || (n >= 22 && n <= 42 && ((n - 22) % 5) == 0);
            checks++;
            if (ifc.fire_pulse_out !== exp_p) begin
                errors++;
                $display("FAIL repeat_pulse n=%0d got=%b exp=%b", n, ifc.fire_pulse_out, exp_p);
            end
            checks++;
            if (ifc.fire_held_out !== (n >= 7 && n < 47)) begin
                errors++;
                $display("FAIL repeat_held n=%0d got=%b exp=%b", n, ifc.fire_held_out, (n >= 7 && n < 47));
            end
            if (n == 40) ifc.btn_fire_in = 1'b0;
        end
        idle_wait(10);
    endtask

    task automatic test_mutex();
        ifc.btn_right_in = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            step();
            checks++;
            if (ifc.right_out !== (n >= 7 && n < 27)) begin
                errors++;
                $display("FAIL mutex_right n=%0d got=%b exp=%b", n, ifc.right_out, (n >= 7 && n < 27));
            end
            checks++;
            if (ifc.left_out !== (n >= 47)) begin
                errors++;
                $display("FAIL mutex_left n=%0d got=%b exp=%b", n, ifc.left_out, (n >= 47));
            end
            if (n == 20) ifc.btn_left_in = 1'b1;
            if (n == 40) ifc.btn_right_in = 1'b0;
        end
        ifc.btn_left_in = 1'b0;
        idle_wait(10);
    endtask

    task automatic test_reset_repeat();
        logic exp_p;
        logic exp_h;
        ifc.btn_fire_in = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            step();
            exp_p = (n == 7) || (n == 17) || (n == 22) || (n == 32) ||
                    (n == 42) || (n == 47) || (n == 52);
            exp_h = (n >= 7 && n < 25) || (n >= 32);
            checks++;
            if (ifc.fire_pulse_out !== exp_p) begin
                errors++;
                $display("FAIL rstrep_pulse n=%0d got=%b exp=%b", n, ifc.fire_pulse_out, exp_p);
            end
            checks++;
            if (ifc.fire_held_out !== exp_h) begin
                errors++;
                $display("FAIL rstrep_held n=%0d got=%b exp=%b", n, ifc.fire_held_out, exp_h);
            end
            if (n == 24) rst = 1'b1;
            if (n == 25) rst = 1'b0;
        end
        ifc.btn_fire_in = 1'b0;
        idle_wait(10);
    endtask

    initial begin
        ifc.btn_left_in  = 1'b0;
        ifc.btn_right_in = 1'b0;
        ifc.btn_fire_in  = 1'b0;
        @(negedge pclk);
        test_reset();
        test_left_press();
        test_glitch();
        test_fire_repeat();
        test_mutex();
        test_reset_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
